// File: rtl/shift_reg_sequencer_if.sv
// Command channel for shift_reg_sequencer: valid/ready plus the command fields.
// The master offers commands and the slave (the sequencer) accepts them.
interface shift_reg_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_preload;
  logic [WIDTH-1:0] cmd_data;
  logic [AMT_W-1:0] cmd_amount;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_preload,
    output cmd_data,
    output cmd_amount,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_preload,
    input  cmd_data,
    input  cmd_amount,
    output cmd_ready
  );
endinterface

// File: rtl/shift_reg_sequencer.sv
// Sequences load/rotate/ASR commands onto a free-running shift register.
// Define SEQ_ABORT_EN to add the abort input and aborted output.
module shift_reg_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic                 clock,
  input  logic                 reset_value,
  shift_reg_sequencer_if.slave cmd,
  input  logic [WIDTH-1:0]     q_in,
  output logic [WIDTH-1:0]     reg_data,
  output logic                 reg_loadn,
  output logic                 reg_rotate,
  output logic                 reg_asright,
  output logic [WIDTH-1:0]     result,
  output logic                 done
`ifdef SEQ_ABORT_EN
  ,
  input  logic                 abort,
  output logic                 aborted
`endif
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ROL  = 2'b01;
  localparam logic [1:0] OP_ASR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             done_q;
  logic             abort_hit;

`ifdef SEQ_ABORT_EN
  logic abt_q;
  logic aborted_q;
  assign abort_hit = abort;
  assign aborted   = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset_value) begin
      state_q  <= IDLE;
      op_q     <= OP_LOAD;
      data_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
`ifdef SEQ_ABORT_EN
      abt_q     <= 1'b0;
      aborted_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SEQ_ABORT_EN
      aborted_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (cmd.cmd_valid) begin
            op_q   <= cmd.cmd_op;
            data_q <= cmd.cmd_data;
            cnt_q  <= (cmd.cmd_op == OP_LOAD) ? '0 : cmd.cmd_amount;
`ifdef SEQ_ABORT_EN
            abt_q <= 1'b0;
`endif
            if (cmd.cmd_op == OP_LOAD || cmd.cmd_preload)
              state_q <= LOAD;
            else if (cmd.cmd_amount != '0)
              state_q <= SHIFT;
            else
              state_q <= DONE;
          end
        end
        LOAD: begin
          // cnt_q is zero for LOAD ops, so one test covers both exits
          if (abort_hit || cnt_q == '0)
            state_q <= DONE;
          else
            state_q <= SHIFT;
`ifdef SEQ_ABORT_EN
          abt_q <= abort_hit;
`endif
        end
        SHIFT: begin
          cnt_q <= cnt_q - AMT_W'(1);
          if (abort_hit || cnt_q == AMT_W'(1))
            state_q <= DONE;
`ifdef SEQ_ABORT_EN
          abt_q <= abort_hit;
`endif
        end
        DONE: begin
          result_q <= q_in;
          done_q   <= 1'b1;
          state_q  <= IDLE;
`ifdef SEQ_ABORT_EN
          aborted_q <= abt_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Hold states reload q so the register never free-runs
  always_comb begin
    reg_data    = q_in;
    reg_loadn   = 1'b0;
    reg_rotate  = 1'b0;
    reg_asright = 1'b0;
    unique case (state_q)
      LOAD:  reg_data = data_q;
      SHIFT: begin
        reg_loadn   = 1'b1;
        reg_rotate  = (op_q != OP_ROL);
        reg_asright = (op_q == OP_ASR);
      end
      default: ;
    endcase
  end

  assign cmd.cmd_ready = (state_q == IDLE);
  assign result        = result_q;
  assign done          = done_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer with a behavioural register attached.
// Define SEQ_ABORT_EN to also exercise abort.
module tb_shift_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] q;
  logic [7:0] reg_data;
  logic       reg_loadn;
  logic       reg_rotate;
  logic       reg_asright;
  logic [7:0] result;
  logic       done;
`ifdef SEQ_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int checks = 0;
  int errors = 0;

  shift_reg_sequencer_if #(.WIDTH(8), .AMT_W(3)) cmd ();

  shift_reg_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
    .clock       (clk),
    .reset_value (rst),
    .cmd         (cmd.slave),
    .q_in        (q),
    .reg_data    (reg_data),
    .reg_loadn   (reg_loadn),
    .reg_rotate  (reg_rotate),
    .reg_asright (reg_asright),
    .result      (result),
    .done        (done)
`ifdef SEQ_ABORT_EN
    ,
    .abort       (abort),
    .aborted     (aborted)
`endif
  );

  always #5 clk = ~clk;

  // The external register: resets to all ones, no hold mode
  always_ff @(posedge clk) begin
    if (rst)              q <= 8'hFF;
    else if (!reg_loadn)  q <= reg_data;
    else if (!reg_rotate) q <= {q[6:0], q[7]};
    else if (reg_asright) q <= {q[7], q[7:1]};
    else                  q <= {q[0], q[7:1]};
  end

  typedef struct {
    logic [1:0] op;
    logic       pre;
    logic [7:0] data;
    logic [2:0] amt;
    logic [7:0] res;
    int         lat;
    int         sh;
    logic       rot;
    logic       asr;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic pre,
                       input logic [7:0] data, input logic [2:0] amt);
    cmd.cmd_valid   = 1'b1;
    cmd.cmd_op      = op;
    cmd.cmd_preload = pre;
    cmd.cmd_data    = data;
    cmd.cmd_amount  = amt;
    step();
    cmd.cmd_valid = 1'b0;
    cmd.cmd_data  = ~data;
    cmd.cmd_amount = 3'd6;
  endtask

  initial begin
    int cyc;
    int shifts;
    int bad;

    vecs[0] = '{2'b00, 1'b0, 8'hA5, 3'd0, 8'hA5, 3,  0, 1'b0, 1'b0};
    vecs[1] = '{2'b01, 1'b1, 8'h81, 3'd3, 8'h0C, 6,  3, 1'b0, 1'b0};
    vecs[2] = '{2'b10, 1'b1, 8'h96, 3'd2, 8'hA5, 5,  2, 1'b1, 1'b0};
    vecs[3] = '{2'b11, 1'b1, 8'h80, 3'd7, 8'hFF, 10, 7, 1'b1, 1'b1};
    vecs[4] = '{2'b11, 1'b0, 8'h00, 3'd0, 8'hFF, 2,  0, 1'b1, 1'b1};
    vecs[5] = '{2'b00, 1'b1, 8'h3C, 3'd5, 8'h3C, 3,  0, 1'b0, 1'b0};
    vecs[6] = '{2'b01, 1'b0, 8'h55, 3'd2, 8'hF0, 4,  2, 1'b0, 1'b0};
    vecs[7] = '{2'b10, 1'b0, 8'hAA, 3'd4, 8'h0F, 6,  4, 1'b1, 1'b0};
    vecs[8] = '{2'b11, 1'b1, 8'hC3, 3'd1, 8'hE1, 4,  1, 1'b1, 1'b1};
    vecs[9] = '{2'b10, 1'b1, 8'h01, 3'd7, 8'h02, 10, 7, 1'b1, 1'b0};

    rst             = 1'b1;
    cmd.cmd_valid   = 1'b0;
    cmd.cmd_op      = 2'b00;
    cmd.cmd_preload = 1'b0;
    cmd.cmd_data    = 8'h00;
    cmd.cmd_amount  = 3'd0;
`ifdef SEQ_ABORT_EN
    abort = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      check($sformatf("idle%0d ready", i), 32'(cmd.cmd_ready), 32'd1);
      check($sformatf("idle%0d done", i), 32'(done), 32'd0);
      check($sformatf("idle%0d result", i), 32'(result), 32'h00);
      check($sformatf("idle%0d loadn", i), 32'(reg_loadn), 32'd0);
      check($sformatf("idle%0d q", i), 32'(q), 32'hFF);
      step();
    end

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].pre, vecs[i].data, vecs[i].amt);
      shifts = 0;
      bad = 0;
      for (cyc = 1; cyc < 40; cyc++) begin
        if (done) break;
        if (cmd.cmd_ready) bad++;
        if (reg_loadn) begin
          shifts++;
          if (reg_rotate !== vecs[i].rot || reg_asright !== vecs[i].asr)
            bad++;
        end
        step();
      end
      check($sformatf("v%0d latency", i), 32'(cyc), 32'(vecs[i].lat));
      check($sformatf("v%0d shifts", i), 32'(shifts), 32'(vecs[i].sh));
      check($sformatf("v%0d busy ctrl", i), 32'(bad), 32'd0);
      check($sformatf("v%0d result", i), 32'(result), 32'(vecs[i].res));
      check($sformatf("v%0d ready", i), 32'(cmd.cmd_ready), 32'd1);
`ifdef SEQ_ABORT_EN
      check($sformatf("v%0d aborted", i), 32'(aborted), 32'd0);
`endif
      bad = 0;
      for (int k = 0; k < 5; k++) begin
        step();
        if (done !== 1'b0 || q !== vecs[i].res || reg_loadn !== 1'b0)
          bad++;
      end
      check($sformatf("v%0d hold", i), 32'(bad), 32'd0);
    end

    // back-to-back with cmd_valid held high
    issue(2'b00, 1'b0, 8'h11, 3'd0);
    step();
    step();
    check("b2b load", 32'(result), 32'h11);
    cmd.cmd_valid   = 1'b1;
    cmd.cmd_op      = 2'b01;
    cmd.cmd_preload = 1'b0;
    cmd.cmd_amount  = 3'd1;
    cmd.cmd_data    = 8'h00;
    step();
    check("b2b c1 ready", 32'(cmd.cmd_ready), 32'd0);
    cmd.cmd_data = 8'h77;
    step();
    check("b2b c2 ready", 32'(cmd.cmd_ready), 32'd0);
    cmd.cmd_data = 8'h99;
    step();
    check("b2b done1", 32'(done), 32'd1);
    check("b2b result1", 32'(result), 32'h22);
    check("b2b ready1", 32'(cmd.cmd_ready), 32'd1);
    step();
    check("b2b accept2", 32'(cmd.cmd_ready), 32'd0);
    check("b2b done low", 32'(done), 32'd0);
    step();
    step();
    check("b2b done2", 32'(done), 32'd1);
    check("b2b result2", 32'(result), 32'h44);
    cmd.cmd_valid = 1'b0;
    step();
    check("b2b idle ready", 32'(cmd.cmd_ready), 32'd1);
    check("b2b idle done", 32'(done), 32'd0);
    check("b2b idle q", 32'(q), 32'h44);

    // reset on the 2nd SHIFT cycle
    issue(2'b01, 1'b1, 8'h01, 3'd5);
    step();
    check("rst shifting", 32'(reg_loadn), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst ready", 32'(cmd.cmd_ready), 32'd1);
    check("rst done", 32'(done), 32'd0);
    check("rst result", 32'(result), 32'h00);
    check("rst q", 32'(q), 32'hFF);
    check("rst loadn", 32'(reg_loadn), 32'd0);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done !== 1'b0 || q !== 8'hFF) bad++;
    end
    check("rst settle", 32'(bad), 32'd0);

`ifdef SEQ_ABORT_EN
    issue(2'b01, 1'b1, 8'h01, 3'd5);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort no done yet", 32'(done), 32'd0);
    step();
    check("abort done", 32'(done), 32'd1);
    check("abort aborted", 32'(aborted), 32'd1);
    check("abort result", 32'(result), 32'h04);
    step();
    check("abort clear", 32'(aborted), 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort idle ignored", 32'(cmd.cmd_ready), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
Name: shift_reg_sequencer

Overview:
- Command-driven controller for the team's 8-bit load/rotate/arithmetic-shift register.
- The register has no hold/enable: it shifts on every clock with loadn=1, and loads on every clock with loadn=0.
- This block accepts one command at a time over a valid/ready handshake and drives the register's data, loadn, rotate and asright inputs for the exact number of cycles.
- It holds the register between commands and returns the final register value with a one-cycle done pulse.

Parameters:
- WIDTH, 8, register data width.
- AMT_W, 3, width of the shift-amount field; amounts 0..2^AMT_W-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_value  in  1  synchronous active-high reset. It is shared with the register, which resets to all ones.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  operation: 00 LOAD, 01 ROL, 10 ROR, 11 ASR.
- cmd_preload  in  1  for ROL/ROR/ASR only: load cmd_data before shifting.
- cmd_data  in  WIDTH  value to load.
- cmd_amount  in  AMT_W  number of shift steps.
- q_in  in  WIDTH  register output q.
- reg_data  out  WIDTH  register parallel data.
- reg_loadn  out  1  register loadn (0 = load).
- reg_rotate  out  1  register rotate (0 = left, 1 = right).
- reg_asright  out  1  register asright (1 = MSB fill on right shift).
- result  out  WIDTH  register value captured at completion.
- done  out  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. A command is accepted on an edge where cmd_valid=1 and the state is IDLE. op, preload, data and amount are latched at that edge.
- Transitions out of IDLE on accept:
  - LOAD op, or a shift op with preload=1: go to LOAD.
  - Otherwise, amount>0: go to SHIFT.
  - Otherwise: go to DONE.
- LOAD (1 cycle): reg_loadn=0, reg_data=latched data.
  - Next state: SHIFT if the op is a shift op and amount>0; otherwise DONE.
- SHIFT (exactly amount cycles):
  - reg_loadn=0→1.
  - ROL: rotate=0, asright=0.
  - ROR: rotate=1, asright=0.
  - ASR: rotate=1, asright=1.
  - A down-counter is loaded with amount. On the edge where the counter equals 1, the state moves to DONE.
- IDLE and DONE (hold): reg_loadn=0, reg_data=q_in, rotate=0, asright=0. This reloads the current value every cycle, so the register never drifts.
- DONE (1 cycle): on its exit edge, result<=q_in and done<=1 for the following cycle (IDLE). State goes to IDLE.
- Latency:
  - From accept edge to done high: 1 + preload + amount + 1 cycles, with a registered done.
  - LOAD op: done is high in the 3rd cycle after the accept edge.
  - A new command may be accepted in the same cycle that done is high.
- cmd_valid while not in IDLE: ignored. cmd_ready=0; no latching.
- The cmd_amount field is ignored for LOAD. cmd_preload is ignored for LOAD.
- Reset (any state, including mid-SHIFT):
  - Next cycle: state=IDLE, counter=0, result=0, done=0, cmd_ready=1.
  - Control outputs take their hold values. The register itself is at all ones.
- Outputs are combinational from the registered state and latched command only. There is no combinational path from cmd_* to reg_*.

Optional Feature:
- Macro: SEQ_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort=1 on an edge in LOAD or SHIFT: the state moves to DONE; remaining steps are skipped. The register keeps the steps already applied.
  - aborted is high together with done for that completion; otherwise it is 0.
  - abort in IDLE/DONE is ignored.
- Undefined: no abort/aborted ports. Every command always runs to completion.

Test Plan:
- Reset, then 10 idle cycles, with the register attached: cmd_ready=1, done=0, result=0x00, reg_loadn=0, q stays 0xFF.
- LOAD data=0xA5: done pulses in the 3rd cycle after accept; result=0xA5. q holds 0xA5 for 5 further idle cycles.
- ROL, preload=1, data=0x81, amount=3: exactly 3 cycles with reg_loadn=1, rotate=0; result=0x0C. Then ROR, preload=1, data=0x96, amount=2: result=0xA5.
- ASR, preload=1, data=0x80, amount=7: result=0xFF. Then ASR, preload=0, amount=0: no SHIFT cycles, done 2 cycles after accept, result=0xFF.
- Hold cmd_valid high continuously across back-to-back ROL amount=1 commands:
  - Each command is accepted only in IDLE.
  - The second command is accepted in the same cycle the first command's done is high.
  - Busy-cycle cmd_data changes do not alter the result.
- Reset asserted on the 2nd SHIFT cycle of ROL amount=5: next cycle IDLE, done=0, result=0x00, q=0xFF. With SEQ_ABORT_EN, abort on the 2nd SHIFT cycle of ROL 0x01 amount=5 gives done=1, aborted=1, result=0x04.
